// File: rtl/lcd_reader.sv
// HD44780-style LCD bus reader: one timed read cycle per request, optional busy-flag polling.
// Build with LCD_BUSY_POLL_EN defined to enable the poll_req busy-flag loop and its 2 ms timeout.
module lcd_reader #(
  parameter int unsigned CLK_FREQ    = 100000000,
  parameter int unsigned TIMEOUT_CYC = CLK_FREQ / 500
) (
  input  logic       clock,
  input  logic       internal_reset_n,
  input  logic       read_req,
  input  logic       read_rs,
  input  logic       poll_req,
  input  logic [7:0] d_pad,
  output logic       rs,
  output logic       rw,
  output logic       e,
  output logic [7:0] read_data,
  output logic       data_valid,
  output logic       busy,
  output logic       poll_done,
  output logic       poll_timeout
);

  localparam int unsigned MHZ       = CLK_FREQ / 1000000;
  localparam int unsigned SETUP_CYC = MHZ * 60 / 1000;
  localparam int unsigned EH_CYC    = MHZ * 500 / 1000;
  localparam int unsigned CAP_CYC   = MHZ * 450 / 1000;
  localparam int unsigned REC_CYC   = MHZ * 1000 / 1000 - SETUP_CYC - EH_CYC;

  // Counters hold "cycles already spent", so each state ends on count N-1.
  localparam logic [17:0] SETUP_LAST = 18'(SETUP_CYC - 1);
  localparam logic [17:0] EH_LAST    = 18'(EH_CYC - 1);
  localparam logic [17:0] CAP_LAST   = 18'(CAP_CYC - 1);
  localparam logic [17:0] REC_LAST   = 18'(REC_CYC - 1);

`ifdef LCD_BUSY_POLL_EN
  typedef enum logic [2:0] {IDLE, SETUP, E_HIGH, RECOVER, POLL_CHECK} state_t;
  localparam logic [17:0] TO_LIMIT = 18'(TIMEOUT_CYC);
  logic        poll_q, poll_d;
  logic        pd_q, pd_d;
  logic        pt_q, pt_d;
  logic [17:0] to_cnt_q, to_cnt_d;
`else
  typedef enum logic [1:0] {IDLE, SETUP, E_HIGH, RECOVER} state_t;
  logic unused_poll_req;
  assign unused_poll_req = poll_req;
`endif

  state_t      state_q, state_d;
  logic [17:0] cnt_q, cnt_d;
  logic [1:0]  sync_q, sync_d;
  logic        rs_q, rs_d;
  logic        rw_q, rw_d;
  logic        e_q, e_d;
  logic [7:0]  rd_q, rd_d;
  logic        dv_q, dv_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 18'd1;
    sync_d  = {sync_q[0], 1'b1};
    rs_d    = rs_q;
    rw_d    = rw_q;
    e_d     = e_q;
    rd_d    = rd_q;
    dv_d    = 1'b0;
    busy_d  = busy_q;
`ifdef LCD_BUSY_POLL_EN
    poll_d   = poll_q;
    pd_d     = 1'b0;
    pt_d     = 1'b0;
    to_cnt_d = (poll_q && to_cnt_q != TO_LIMIT) ? to_cnt_q + 18'd1 : to_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Requests are held off until reset release has crossed the synchroniser.
        if (sync_q[1]) begin
          if (read_req) begin
            rs_d    = read_rs;
            rw_d    = 1'b1;
            busy_d  = 1'b1;
            state_d = SETUP;
`ifdef LCD_BUSY_POLL_EN
            poll_d  = 1'b0;
          end else if (poll_req) begin
            rs_d     = 1'b0;
            rw_d     = 1'b1;
            busy_d   = 1'b1;
            poll_d   = 1'b1;
            to_cnt_d = '0;
            state_d  = SETUP;
`endif
          end
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          e_d     = 1'b1;
          cnt_d   = '0;
          state_d = E_HIGH;
        end
      end
      E_HIGH: begin
        if (cnt_q == CAP_LAST) rd_d = d_pad;
        if (cnt_q == EH_LAST) begin
          e_d     = 1'b0;
          cnt_d   = '0;
          state_d = RECOVER;
        end
      end
      RECOVER: begin
        if (cnt_q == REC_LAST) begin
          rw_d  = 1'b0;
          cnt_d = '0;
`ifdef LCD_BUSY_POLL_EN
          if (poll_q) begin
            state_d = POLL_CHECK;
          end else begin
            dv_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
`else
          dv_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
`endif
        end
      end
`ifdef LCD_BUSY_POLL_EN
      POLL_CHECK: begin
        cnt_d = '0;
        // A clear busy flag wins over a timeout that expired during the same cycle.
        if (!rd_q[7]) begin
          dv_d    = 1'b1;
          pd_d    = 1'b1;
          busy_d  = 1'b0;
          poll_d  = 1'b0;
          state_d = IDLE;
        end else if (to_cnt_q == TO_LIMIT) begin
          pt_d    = 1'b1;
          busy_d  = 1'b0;
          poll_d  = 1'b0;
          state_d = IDLE;
        end else begin
          rw_d    = 1'b1;
          state_d = SETUP;
        end
      end
`endif
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge internal_reset_n) begin
    if (!internal_reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sync_q   <= '0;
      rs_q     <= 1'b0;
      rw_q     <= 1'b0;
      e_q      <= 1'b0;
      rd_q     <= '0;
      dv_q     <= 1'b0;
      busy_q   <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
      poll_q   <= 1'b0;
      pd_q     <= 1'b0;
      pt_q     <= 1'b0;
      to_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sync_q   <= sync_d;
      rs_q     <= rs_d;
      rw_q     <= rw_d;
      e_q      <= e_d;
      rd_q     <= rd_d;
      dv_q     <= dv_d;
      busy_q   <= busy_d;
`ifdef LCD_BUSY_POLL_EN
      poll_q   <= poll_d;
      pd_q     <= pd_d;
      pt_q     <= pt_d;
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  assign rs         = rs_q;
  assign rw         = rw_q;
  assign e          = e_q;
  assign read_data  = rd_q;
  assign data_valid = dv_q;
  assign busy       = busy_q;
`ifdef LCD_BUSY_POLL_EN
  assign poll_done    = pd_q;
  assign poll_timeout = pt_q;
`else
  assign poll_done    = 1'b0;
  assign poll_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_reader.sv
// Scoreboard bench for lcd_reader: stimulus pushes expected result events, a monitor pops them.
module tb_lcd_reader;
  localparam int TO = 1000;

  logic       clock = 1'b0;
  logic       internal_reset_n = 1'b0;
  logic       read_req = 1'b0, read_rs = 1'b0, poll_req = 1'b0;
  logic [7:0] d_pad = 8'h00;
  logic       rs, rw, e, data_valid, busy, poll_done, poll_timeout;
  logic [7:0] read_data;

  lcd_reader #(.CLK_FREQ(100000000), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .internal_reset_n(internal_reset_n),
    .read_req(read_req), .read_rs(read_rs), .poll_req(poll_req), .d_pad(d_pad),
    .rs(rs), .rw(rw), .e(e), .read_data(read_data), .data_valid(data_valid),
    .busy(busy), .poll_done(poll_done), .poll_timeout(poll_timeout)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // kind = {poll_timeout, poll_done, data_valid}
  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (internal_reset_n && (data_valid || poll_done || poll_timeout)) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", {29'd0, poll_timeout, poll_done, data_valid}, 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("event_kind", {29'd0, poll_timeout, poll_done, data_valid}, {29'd0, x.kind});
        chk("event_data", {24'd0, read_data}, {24'd0, x.data});
        chk("event_cycle", cyc, x.at);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Called at a negedge; returns with acc = cycle count just after the accepting edge.
  task automatic issue(input logic rq, input logic pq, input logic rsv);
    read_req = rq;
    poll_req = pq;
    read_rs  = rsv;
    @(negedge clock);
    read_req = 1'b0;
    poll_req = 1'b0;
    acc = cyc;
  endtask

  task automatic push(input logic [2:0] kind, input logic [7:0] data, input int at);
    exp_t x;
    x.kind = kind;
    x.data = data;
    x.at   = at;
    sb.push_back(x);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=%0d expected=done", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    tick(3);
    chk("rst_rs", rs, 0);
    chk("rst_rw", rw, 0);
    chk("rst_e", e, 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {data_valid, poll_done, poll_timeout}, 0);

    // Request on the first edge after release must be ignored.
    internal_reset_n = 1'b1;
    read_req = 1'b1;
    read_rs  = 1'b1;
    @(negedge clock);
    read_req = 1'b0;
    chk("early_req_ignored", busy, 0);
    tick(4);

    // Plain data read: timing of e/rw/busy and 100-cycle latency.
    d_pad = 8'h48;
    issue(1'b1, 1'b0, 1'b1);
    push(3'b001, 8'h48, acc + 100);
    for (int k = 0; k <= 100; k++) begin
      chk($sformatf("read_e_k%0d", k), e, (k >= 6 && k <= 55) ? 1 : 0);
      chk($sformatf("read_rw_k%0d", k), rw, (k <= 99) ? 1 : 0);
      chk($sformatf("read_busy_k%0d", k), busy, (k <= 99) ? 1 : 0);
      if (k <= 99) chk($sformatf("read_rs_k%0d", k), rs, 1);
      if (k < 100) @(negedge clock);
    end
    chk("read_data_held", read_data, 8'h48);
    tick(5);

    // Repeated requests while busy are dropped.
    d_pad = 8'h5A;
    issue(1'b1, 1'b0, 1'b0);
    push(3'b001, 8'h5A, acc + 100);
    tick(29);
    read_req = 1'b1;
    poll_req = 1'b1;
    read_rs  = 1'b1;
    @(negedge clock);
    read_req = 1'b0;
    poll_req = 1'b0;
    chk("busy_req_rs_kept", rs, 0);
    tick(200);
    chk("busy_req_drain", sb.size(), 0);
    chk("busy_req_idle", busy, 0);

    // Asynchronous reset in the middle of E_HIGH.
    d_pad = 8'h77;
    issue(1'b1, 1'b0, 1'b1);
    push(3'b001, 8'h77, acc + 100);
    tick(20);
    chk("pre_reset_e", e, 1);
    #2;
    internal_reset_n = 1'b0;
    #1;
    chk("async_rst_e", e, 0);
    chk("async_rst_rw", rw, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_read_data", read_data, 0);
    sb.delete();
    tick(2);
    internal_reset_n = 1'b1;
    tick(5);

`ifdef LCD_BUSY_POLL_EN
    // Simultaneous read and poll: the read wins.
    d_pad = 8'h33;
    issue(1'b1, 1'b1, 1'b1);
    push(3'b001, 8'h33, acc + 100);
    chk("prio_rs", rs, 1);
    tick(130);
    chk("prio_drain", sb.size(), 0);

    // Busy for three reads, then clear: done after four 101-cycle passes.
    d_pad = 8'h85;
    issue(1'b0, 1'b1, 1'b1);
    push(3'b011, 8'h05, acc + 404);
    chk("poll_rs", rs, 0);
    chk("poll_busy", busy, 1);
    tick(303);
    d_pad = 8'h05;
    tick(150);
    chk("poll_drain", sb.size(), 0);
    chk("poll_idle", busy, 0);

    // Stuck busy flag: timeout at the first check with elapsed >= TO.
    d_pad = 8'h80;
    issue(1'b0, 1'b1, 1'b0);
    push(3'b100, 8'h80, acc + 101 * ((TO + 101) / 101));
    tick(1200);
    chk("timeout_drain", sb.size(), 0);
    chk("timeout_idle", busy, 0);
`else
    // Without the poll feature poll_req does nothing.
    d_pad = 8'h05;
    issue(1'b0, 1'b1, 1'b0);
    chk("poll_ignored_busy", busy, 0);
    tick(150);
    chk("poll_ignored_rw", rw, 0);
    chk("poll_ignored_drain", sb.size(), 0);
`endif

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
